// File: rtl/arc_ctrl_pkg.sv
// Shared types and encodings for the ARC multi-cycle main control.
// States, opcodes, ALU control codes and datapath mux selects.
package arc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REX, S_RWB, S_BEQ, S_BNE, S_IEX, S_IWB, S_J, S_JAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE = 2'd2;
  localparam logic [1:0] ALUOP_OTHER = 2'd3;

  localparam logic [3:0] OTHER_ADDI = 4'd0;
  localparam logic [3:0] OTHER_ANDI = 4'd1;
  localparam logic [3:0] OTHER_ORI  = 4'd2;
  localparam logic [3:0] OTHER_XORI = 4'd3;
  localparam logic [3:0] OTHER_BNE  = 4'd5;
  localparam logic [3:0] OTHER_SLTI = 4'd6;
  localparam logic [3:0] OTHER_LUI  = 4'd7;
  localparam logic [3:0] OTHER_JAL  = 4'd8;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
  localparam logic [1:0] MEMTOREG_PC     = 2'd2;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] other;
    logic [1:0] pc_source;
  } ctrl_t;

  // I-type sub-op handed to alu_control during IEX/IWB.
  function automatic logic [3:0] other_for_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return OTHER_ANDI;
      OP_ORI:  return OTHER_ORI;
      OP_XORI: return OTHER_XORI;
      OP_SLTI: return OTHER_SLTI;
      OP_LUI:  return OTHER_LUI;
      default: return OTHER_ADDI;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode: state (+opcode, MemReady, jumpreg) -> datapath controls.
// Memory-side enables are qualified by MemReady so a stalled access never commits.
module mc_ctrl_outdec
  import arc_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_jumpreg,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMMSH;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RT;
        o_ctrl.mem_to_reg = MEMTOREG_MDR;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = i_mem_ready;
        o_ctrl.iord      = 1'b1;
      end
      S_REX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALUOP_RTYPE;
        if (i_jumpreg) begin
          o_ctrl.pc_write  = 1'b1;
          o_ctrl.pc_source = PCSRC_RS;
        end
      end
      S_RWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RD;
        o_ctrl.mem_to_reg = MEMTOREG_ALUOUT;
        o_ctrl.alu_op     = ALUOP_RTYPE;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_BNE: begin
        o_ctrl.alu_src_a        = 1'b1;
        o_ctrl.alu_op           = ALUOP_OTHER;
        o_ctrl.other            = OTHER_BNE;
        o_ctrl.pc_write_cond_ne = 1'b1;
        o_ctrl.pc_source        = PCSRC_ALUOUT;
      end
      S_IEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_OTHER;
        o_ctrl.other     = other_for_op(i_opcode);
      end
      S_IWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_OTHER;
        o_ctrl.other     = other_for_op(i_opcode);
      end
      S_J: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RA;
        o_ctrl.mem_to_reg = MEMTOREG_PC;
        o_ctrl.alu_op     = ALUOP_OTHER;
        o_ctrl.other      = OTHER_JAL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM with memory-ready stall watchdog for the ARC MIPS core.
// Outputs are combinational from state; MemReady gates fetch/store enables and timeout exits.
module mc_main_control
  import arc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_con_Opcode,
  input  logic       i_con_jumpreg,
  input  logic       i_con_MemReady,
  output logic       o_con_PCWrite,
  output logic       o_con_PCWriteCond,
  output logic       o_con_PCWriteCondNe,
  output logic       o_con_IorD,
  output logic       o_con_MemRead,
  output logic       o_con_MemWrite,
  output logic       o_con_IRWrite,
  output logic       o_con_RegWrite,
  output logic [1:0] o_con_RegDst,
  output logic [1:0] o_con_MemtoReg,
  output logic       o_con_ALUSrcA,
  output logic [1:0] o_con_ALUSrcB,
  output logic [1:0] o_con_AluOp,
  output logic [3:0] o_con_Other,
  output logic [1:0] o_con_PCSource,
  output logic       o_con_Illegal,
  output logic       o_con_MemTimeout
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               w_waiting;
  logic               w_expire;
  logic               w_illegal;
  ctrl_t              w_ctrl;

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // Ready on the expiry cycle takes precedence over the timeout.
  assign w_expire  = w_waiting && !i_con_MemReady && (r_wait_cnt == CNT_W'(MEM_WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RST;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_waiting && !i_con_MemReady && !w_expire)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else
        r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  if (i_con_MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (i_con_Opcode)
          OP_LW, OP_SW:                    w_next = S_MEMADR;
          OP_RTYPE:                        w_next = S_REX;
          OP_BEQ:                          w_next = S_BEQ;
          OP_BNE:                          w_next = S_BNE;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_XORI, OP_SLTI, OP_LUI:        w_next = S_IEX;
          OP_J:                            w_next = S_J;
          OP_JAL:                          w_next = S_JAL;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: w_next = (i_con_Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (i_con_MemReady) w_next = S_MEMWB;
      S_MEMWR:  if (i_con_MemReady) w_next = S_FETCH;
      S_REX:    w_next = i_con_jumpreg ? S_FETCH : S_RWB;
      S_IEX:    w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
    if (w_expire)
      w_next = S_FETCH;
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_opcode    (i_con_Opcode),
    .i_mem_ready (i_con_MemReady),
    .i_jumpreg   (i_con_jumpreg),
    .o_ctrl      (w_ctrl)
  );

  assign o_con_PCWrite       = w_ctrl.pc_write;
  assign o_con_PCWriteCond   = w_ctrl.pc_write_cond;
  assign o_con_PCWriteCondNe = w_ctrl.pc_write_cond_ne;
  assign o_con_IorD          = w_ctrl.iord;
  assign o_con_MemRead       = w_ctrl.mem_read;
  assign o_con_MemWrite      = w_ctrl.mem_write;
  assign o_con_IRWrite       = w_ctrl.ir_write;
  assign o_con_RegWrite      = w_ctrl.reg_write;
  assign o_con_RegDst        = w_ctrl.reg_dst;
  assign o_con_MemtoReg      = w_ctrl.mem_to_reg;
  assign o_con_ALUSrcA       = w_ctrl.alu_src_a;
  assign o_con_ALUSrcB       = w_ctrl.alu_src_b;
  assign o_con_AluOp         = w_ctrl.alu_op;
  assign o_con_Other         = w_ctrl.other;
  assign o_con_PCSource      = w_ctrl.pc_source;
  assign o_con_Illegal       = w_illegal;
  assign o_con_MemTimeout    = w_expire;

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: each stimulus cycle queues the expected control word,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_main_control;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       pcwne;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [3:0] other;
    logic [1:0] pcsrc;
    logic       ill;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       jumpreg = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pcw, pcwc, pcwne, iord, mrd, mwr, irw, rw, srca, ill, tmo;
  logic [1:0] rdst, m2r, srcb, aluop, pcsrc;
  logic [3:0] other;

  int checks = 0;
  int errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  mc_main_control #(.MEM_WAIT_MAX(15)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_con_Opcode        (opcode),
    .i_con_jumpreg       (jumpreg),
    .i_con_MemReady      (mem_ready),
    .o_con_PCWrite       (pcw),
    .o_con_PCWriteCond   (pcwc),
    .o_con_PCWriteCondNe (pcwne),
    .o_con_IorD          (iord),
    .o_con_MemRead       (mrd),
    .o_con_MemWrite      (mwr),
    .o_con_IRWrite       (irw),
    .o_con_RegWrite      (rw),
    .o_con_RegDst        (rdst),
    .o_con_MemtoReg      (m2r),
    .o_con_ALUSrcA       (srca),
    .o_con_ALUSrcB       (srcb),
    .o_con_AluOp         (aluop),
    .o_con_Other         (other),
    .o_con_PCSource      (pcsrc),
    .o_con_Illegal       (ill),
    .o_con_MemTimeout    (tmo)
  );

  // Hand-written expected control words, one per state.
  function automatic exp_t e_zero();
    exp_t e; e = '0; return e;
  endfunction
  function automatic exp_t e_fetch(input logic rdy);
    exp_t e; e = '0; e.mrd = 1; e.srcb = 2'd1; e.irw = rdy; e.pcw = rdy; return e;
  endfunction
  function automatic exp_t e_tmo();
    exp_t e; e = e_fetch(1'b0); e.tmo = 1; return e;
  endfunction
  function automatic exp_t e_decode(input logic illegal);
    exp_t e; e = '0; e.srcb = 2'd3; e.ill = illegal; return e;
  endfunction
  function automatic exp_t e_memadr();
    exp_t e; e = '0; e.srca = 1; e.srcb = 2'd2; return e;
  endfunction
  function automatic exp_t e_memrd();
    exp_t e; e = '0; e.mrd = 1; e.iord = 1; return e;
  endfunction
  function automatic exp_t e_memwb();
    exp_t e; e = '0; e.rw = 1; e.m2r = 2'd1; return e;
  endfunction
  function automatic exp_t e_memwr(input logic rdy);
    exp_t e; e = '0; e.mwr = rdy; e.iord = 1; return e;
  endfunction
  function automatic exp_t e_rex(input logic jr);
    exp_t e; e = '0; e.srca = 1; e.aluop = 2'd2;
    if (jr) begin e.pcw = 1; e.pcsrc = 2'd3; end
    return e;
  endfunction
  function automatic exp_t e_rwb();
    exp_t e; e = '0; e.rw = 1; e.rdst = 2'd1; e.aluop = 2'd2; return e;
  endfunction
  function automatic exp_t e_beq();
    exp_t e; e = '0; e.srca = 1; e.aluop = 2'd1; e.pcwc = 1; e.pcsrc = 2'd1; return e;
  endfunction
  function automatic exp_t e_bne();
    exp_t e; e = '0; e.srca = 1; e.aluop = 2'd3; e.other = 4'd5; e.pcwne = 1; e.pcsrc = 2'd1; return e;
  endfunction
  function automatic exp_t e_iex(input logic [3:0] oth);
    exp_t e; e = '0; e.srca = 1; e.srcb = 2'd2; e.aluop = 2'd3; e.other = oth; return e;
  endfunction
  function automatic exp_t e_iwb(input logic [3:0] oth);
    exp_t e; e = '0; e.rw = 1; e.aluop = 2'd3; e.other = oth; return e;
  endfunction
  function automatic exp_t e_j();
    exp_t e; e = '0; e.pcw = 1; e.pcsrc = 2'd2; return e;
  endfunction
  function automatic exp_t e_jal();
    exp_t e; e = '0; e.pcw = 1; e.pcsrc = 2'd2; e.rw = 1; e.rdst = 2'd2; e.m2r = 2'd2;
    e.aluop = 2'd3; e.other = 4'd8; return e;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue what this state must show.
  task automatic cyc(input logic [5:0] op, input logic rdy, input logic jr,
                     input exp_t e, input string nm);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    jumpreg   = jr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {pcw, pcwc, pcwne, iord, mrd, mwr, irw, rw, rdst, m2r, srca, srcb,
            aluop, other, pcsrc, ill, tmo};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1);
  end

  initial begin
    // Reset held, then first cycle after release is still S_RST.
    cyc(6'd0, 1, 0, e_zero(), "reset_held");
    @(posedge clk); #1; rst_n = 1'b1;
    exp_q.push_back(e_zero()); name_q.push_back("rst_state");

    // R-type add: 4 cycles.
    cyc(6'd0, 1, 0, e_fetch(1), "r_fetch");
    cyc(6'd0, 1, 0, e_decode(0), "r_decode");
    cyc(6'd0, 1, 0, e_rex(0), "r_rex");
    cyc(6'd0, 1, 0, e_rwb(), "r_rwb");

    // lw with three stall cycles in MEMRD.
    cyc(6'd35, 1, 0, e_fetch(1), "lw_fetch");
    cyc(6'd35, 1, 0, e_decode(0), "lw_decode");
    cyc(6'd35, 1, 0, e_memadr(), "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(6'd35, 0, 0, e_memrd(), "lw_memrd_wait");
    cyc(6'd35, 1, 0, e_memrd(), "lw_memrd_done");
    cyc(6'd35, 1, 0, e_memwb(), "lw_memwb");

    // bne then beq.
    cyc(6'd5, 1, 0, e_fetch(1), "bne_fetch");
    cyc(6'd5, 1, 0, e_decode(0), "bne_decode");
    cyc(6'd5, 1, 0, e_bne(), "bne_exec");
    cyc(6'd4, 1, 0, e_fetch(1), "beq_fetch");
    cyc(6'd4, 1, 0, e_decode(0), "beq_decode");
    cyc(6'd4, 1, 0, e_beq(), "beq_exec");

    // jr: redirect out of REX, no writeback.
    cyc(6'd0, 1, 0, e_fetch(1), "jr_fetch");
    cyc(6'd0, 1, 0, e_decode(0), "jr_decode");
    cyc(6'd0, 1, 1, e_rex(1), "jr_rex");

    // jal then illegal opcode.
    cyc(6'd3, 1, 0, e_fetch(1), "jal_fetch");
    cyc(6'd3, 1, 0, e_decode(0), "jal_decode");
    cyc(6'd3, 1, 0, e_jal(), "jal_exec");
    cyc(6'd63, 1, 0, e_fetch(1), "ill_fetch");
    cyc(6'd63, 1, 0, e_decode(1), "ill_decode");

    // ori (Other=2) and lui (Other=7).
    cyc(6'd13, 1, 0, e_fetch(1), "ori_fetch");
    cyc(6'd13, 1, 0, e_decode(0), "ori_decode");
    cyc(6'd13, 1, 0, e_iex(4'd2), "ori_iex");
    cyc(6'd13, 1, 0, e_iwb(4'd2), "ori_iwb");
    cyc(6'd15, 1, 0, e_fetch(1), "lui_fetch");
    cyc(6'd15, 1, 0, e_decode(0), "lui_decode");
    cyc(6'd15, 1, 0, e_iex(4'd7), "lui_iex");
    cyc(6'd15, 1, 0, e_iwb(4'd7), "lui_iwb");

    // sw, 4 cycles.
    cyc(6'd43, 1, 0, e_fetch(1), "sw_fetch");
    cyc(6'd43, 1, 0, e_decode(0), "sw_decode");
    cyc(6'd43, 1, 0, e_memadr(), "sw_memadr");
    cyc(6'd43, 1, 0, e_memwr(1), "sw_memwr");

    // Fetch watchdog: 15 waits then timeout on the 16th cycle.
    for (int i = 0; i < 15; i++) cyc(6'd8, 0, 0, e_fetch(0), "wd_fetch_wait");
    cyc(6'd8, 0, 0, e_tmo(), "wd_timeout");
    cyc(6'd8, 1, 0, e_fetch(1), "wd_refetch");
    cyc(6'd8, 1, 0, e_decode(0), "addi_decode");
    cyc(6'd8, 1, 0, e_iex(4'd0), "addi_iex");
    cyc(6'd8, 1, 0, e_iwb(4'd0), "addi_iwb");

    // Ready on the expiry cycle wins over the timeout.
    for (int i = 0; i < 15; i++) cyc(6'd2, 0, 0, e_fetch(0), "wd2_fetch_wait");
    cyc(6'd2, 1, 0, e_fetch(1), "wd2_ready_wins");
    cyc(6'd2, 1, 0, e_decode(0), "j_decode");
    cyc(6'd2, 1, 0, e_j(), "j_exec");

    // Async reset in the middle of a stalled store.
    cyc(6'd43, 1, 0, e_fetch(1), "sw2_fetch");
    cyc(6'd43, 1, 0, e_decode(0), "sw2_decode");
    cyc(6'd43, 1, 0, e_memadr(), "sw2_memadr");
    cyc(6'd43, 0, 0, e_memwr(0), "sw2_memwr_wait");
    @(posedge clk); #1; rst_n = 1'b0;
    exp_q.push_back(e_zero()); name_q.push_back("rst_mid_memwr");
    @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b1;
    exp_q.push_back(e_zero()); name_q.push_back("rst_state_again");
    cyc(6'd0, 1, 0, e_fetch(1), "post_rst_fetch");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the ARC MIPS core.
- Sequences fetch/decode/execute/memory/writeback per instruction, and drives datapath muxes, register/PC/IR write enables, and the AluOp/Other codes consumed by alu_control.
- Stalls on a memory ready handshake, with a watchdog.
- Takes jumpreg back from alu_control to redirect on jr.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles waiting for i_con_MemReady before timeout (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_con_Opcode  in  6  IR[31:26], stable from DECODE onward
i_con_jumpreg  in  1  from alu_control, valid while AluOp=2'b10
i_con_MemReady  in  1  memory completes access this cycle
o_con_PCWrite  out  1  unconditional PC load
o_con_PCWriteCond  out  1  PC load if ALU zero (beq)
o_con_PCWriteCondNe  out  1  PC load if ALU non-zero (bne)
o_con_IorD  out  1  0=PC, 1=ALUOut address
o_con_MemRead  out  1  memory read strobe
o_con_MemWrite  out  1  memory write strobe
o_con_IRWrite  out  1  instruction register load
o_con_RegWrite  out  1  register file write
o_con_RegDst  out  2  0=rt, 1=rd, 2=$31
o_con_MemtoReg  out  2  0=ALUOut, 1=MDR, 2=PC(link)
o_con_ALUSrcA  out  1  0=PC, 1=rs
o_con_ALUSrcB  out  2  0=rt, 1=const 4, 2=signext imm, 3=signext imm<<2
o_con_AluOp  out  2  to alu_control
o_con_Other  out  4  to alu_control (I-type/link sub-op)
o_con_PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=rs (jr)
o_con_Illegal  out  1  one-cycle pulse on unknown opcode
o_con_MemTimeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (rst_n=0, async): state=S_RST, wait counter=0, every output 0. S_RST drives all outputs 0 and moves to S_FETCH unconditionally. Reset mid-instruction abandons it; no partial write survives because all enables drop immediately.
- Outputs are Moore decode of state, except the enables gated by i_con_MemReady (marked *).
- S_FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, AluOp=0, PCSource=0, *IRWrite, *PCWrite. Goes to S_DECODE when ready, otherwise holds.
- S_DECODE: ALUSrcA=0, ALUSrcB=3, AluOp=0 (branch target into ALUOut). Next state by opcode:
  - 35 or 43 -> S_MEMADR
  - 0 -> S_REX
  - 4 -> S_BEQ
  - 5 -> S_BNE
  - 8, 12, 13, 14, 10, 15 -> S_IEX
  - 2 -> S_J
  - 3 -> S_JAL
  - other: pulse Illegal, go to S_FETCH
- S_MEMADR: ALUSrcA=1, ALUSrcB=2, AluOp=0. Goes to S_MEMRD (opcode 35) or S_MEMWR (opcode 43).
- S_MEMRD: MemRead=1, IorD=1. Goes to S_MEMWB when ready, otherwise holds.
- S_MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Goes to S_FETCH.
- S_MEMWR: *MemWrite, IorD=1. Goes to S_FETCH when ready.
- S_REX: ALUSrcA=1, ALUSrcB=0, AluOp=2.
  - If i_con_jumpreg=1: PCWrite=1, PCSource=3, go to S_FETCH (no writeback).
  - Otherwise go to S_RWB.
- S_RWB: RegWrite=1, RegDst=1, MemtoReg=0, AluOp=2. Goes to S_FETCH.
- S_BEQ: ALUSrcA=1, ALUSrcB=0, AluOp=1, PCWriteCond=1, PCSource=1. Goes to S_FETCH.
- S_BNE: same as S_BEQ but AluOp=3, Other=5, PCWriteCondNe=1 (PCWriteCond=0).
- S_IEX: ALUSrcA=1, ALUSrcB=2, AluOp=3. Other by opcode: 8->0, 12->1, 13->2, 14->3, 10->6, 15->7. Goes to S_IWB.
- S_IWB: RegWrite=1, RegDst=0, MemtoReg=0, AluOp=3, Other held as in S_IEX. Goes to S_FETCH.
- S_J: PCWrite=1, PCSource=2. Goes to S_FETCH.
- S_JAL: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2, AluOp=3, Other=8. Goes to S_FETCH.
- Outputs not listed for a state are 0.
- Cycle counts with MemReady held 1:
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j/jal: 3
  - jr: 3
- Watchdog:
  - Counter increments each cycle in a waiting state (FETCH/MEMRD/MEMWR) with MemReady=0.
  - Counter clears on leaving the state or on MemReady=1.
  - When counter==MEM_WAIT_MAX and MemReady=0: pulse MemTimeout, clear counter, go to S_FETCH with no IR/PC/Reg/Mem write.
  - MemReady=1 on the expiry cycle wins: normal transition, no pulse.
- Counter width: $clog2(MEM_WAIT_MAX+1); saturation cannot occur.

Decomposition:
- Package arc_ctrl_pkg holds:
  - state enum state_t
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI, OP_J, OP_JAL)
  - AluOp codes (ALUOP_ADD/SUB/RTYPE/OTHER)
  - Other codes
  - PCSource/RegDst/MemtoReg encodings
- One sub-module, mc_ctrl_outdec: combinational state+opcode+MemReady+jumpreg -> control word.
- FSM, watchdog and pulses stay in the top.

Test Plan:
- Release reset, opcode 0, MemReady=1, jumpreg=0 -> S_RST, FETCH(IRWrite=PCWrite=1), DECODE, REX(AluOp=2), RWB(RegWrite=1, RegDst=1); second FETCH at cycle 5.
- Opcode 35, MemReady=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=1, IorD=1 throughout; then MEMWB with MemtoReg=1, RegWrite=1.
- Opcode 5 -> BNE cycle shows AluOp=3, Other=5, PCWriteCondNe=1, PCWriteCond=0; opcode 4 -> AluOp=1, PCWriteCond=1.
- Opcode 0 with jumpreg=1 -> REX asserts PCWrite=1, PCSource=3; next state FETCH; RegWrite never 1.
- Opcode 3 -> JAL: RegDst=2, MemtoReg=2, RegWrite=1, PCWrite=1, Other=8. Opcode 63 -> Illegal pulses 1 cycle in DECODE, then FETCH.
- MEM_WAIT_MAX=15, MemReady=0 in FETCH -> MemTimeout pulses on 16th FETCH cycle, IRWrite stays 0; rst_n low mid-MEMWR -> all outputs 0 immediately, S_RST.
